ad5781_interface: RTL
=====================

// Module: ad5781_interface
// PURPOSE
//  Upstream SPI master for the AD5781 18-bit DAC. Accepts parallel register commands over a
//  valid/ready handshake and serialises each as a 24-bit frame on syncn/sclk/sdin. It
//  drives the DAC resetn/clrn/ldacn pins and captures readback data from sdo.
//  After reset it runs the DAC power-up sequence, including the control-register write.
//  Sits between the gradient sequencer and the DAC pins, or ad5781_model in simulation.
// PARAMETERS
//  SCLK_DIV      2        clk cycles per sclk half-period (>=1)
//  SYNC_SETUP    2        clk cycles: syncn fall->first sclk rise, and last sclk fall->syncn rise
//  SYNC_HIGH     4        min clk cycles syncn held high between frames
//  LDAC_WIDTH    2        clk cycles ldacn held low per load pulse
//  RESET_CYCLES  16       clk cycles dac_resetn_o held low at init
//  INIT_CTRL     20'h2    control-register payload written at init (RBUF=1, DACTRI=OPGND=0)
// PORTS
//  clk            in   1   system clock
//  rst_n          in   1   synchronous, active-low reset
//  data_i         in   18  DAC code / register payload (control payload in data_i[17:0] LSBs)
//  addr_i         in   3   AD5781 register address (000 NOP, 001 DAC, 010 ctrl, 011 clr, 100 sw ctrl)
//  read_i         in   1   1 = readback command
//  ldac_i         in   1   1 = pulse ldacn after frame (honoured only for write to addr 001)
//  valid_i        in   1   command valid
//  ready_o        out  1   idle, can accept command
//  rdata_o        out  24  last readback frame, MSB first
//  rdata_valid_o  out  1   1-cycle pulse when rdata_o updates
//  dac_resetn_o   out  1   DAC RESET pin
//  dac_clrn_o     out  1   DAC CLR pin
//  dac_syncn_o    out  1   DAC SYNC pin
//  dac_sclk_o     out  1   DAC SCLK pin
//  dac_sdin_o     out  1   DAC SDIN pin
//  dac_ldacn_o    out  1   DAC LDAC pin
//  dac_sdo_i      in   1   DAC SDO pin
// BEHAVIOUR
//  Reset values: ready_o=0, rdata_o=0, rdata_valid_o=0, dac_resetn_o=0, dac_clrn_o=0,
//   syncn=1, sclk=0, sdin=0, ldacn=1. rst_n low mid-operation aborts the frame on the next edge.
//  FSM: INIT_RST -> INIT_CLR -> FRAME -> GAP -> [LDAC] -> IDLE. FRAME has sub-phases
//   SETUP/SHIFT/HOLD. INIT_RST holds dac_resetn_o=0 for RESET_CYCLES, then sets it to 1.
//   INIT_CLR raises clrn after SYNC_HIGH cycles, then sends {1'b0,3'b010,INIT_CTRL}.
//  Handshake: command accepted on the edge with valid_i&&ready_o. All inputs are registered
//   then, and ready_o drops the following cycle. valid_i while !ready_o is ignored.
//  Frame word: write = {1'b0,addr_i,data_i,2'b00}; read = {1'b1,addr_i,20'h0}.
//   addr 010/011/100 writes send data_i[17:0] zero-extended to 20 bits, i.e. {1'b0,addr_i,2'b00,data_i}.
//  FRAME timing: syncn=0, then SYNC_SETUP cycles.
//   Then 24 bits MSB first. Per bit: sclk=1 with sdin updated on the same edge for SCLK_DIV cycles,
//   then sclk=0 for SCLK_DIV cycles. The DAC samples on the falling edge.
//   sdo is sampled on the clk edge that drives sclk 1->0.
//   After the last fall: SYNC_SETUP cycles, then syncn=1, sdin=0.
//  GAP: SYNC_HIGH cycles with syncn=1.
//   Write to 001 with ldac_i: LDAC state drives ldacn=0 for LDAC_WIDTH cycles, then IDLE.
//   Otherwise ldacn stays 1.
//  Read: after GAP a second NOP frame {24'h000000} is sent automatically, with sdo shifted in.
//   At its syncn rise rdata_o loads the 24 sampled bits and rdata_valid_o pulses.
//   A second GAP follows, then IDLE. ldac_i is ignored on reads.
//  Latency (defaults): write accept -> ready_o = 1+2+96+2+4 = 105 cycles, +2 with ldac.
//   Read = 2 frames + 2 gaps = 209 cycles.
//  Back-to-back: a command accepted on the cycle ready_o rises starts syncn fall next cycle;
//   the syncn-high gap is therefore >= SYNC_HIGH.
//  Counters: bit counter 5 bits (23..0), phase counter sized for max(all timing params).
// STRUCTURE
//  ad5781_defs.vh: localparams for register addresses, R/W bit position, frame width (24),
//   and NOP/ctrl frame constants; shared with ad5781_model and benches.
//  Sub-module ad5781_spi_shifter: start/done, 24-bit tx word in, 24-bit rx word out,
//   owns syncn/sclk/sdin timing. The parent FSM owns init, gap, ldac, handshake and readback.
// TESTING  (bench instantiates ad5781_interface driving ad5781_model)
//  1 Release rst_n: dac_resetn_o low 16 cycles; clrn rises; frame 24'h200002 captured on pins;
//    ready_o=1; model vout==0.
//  2 Write addr 001, data 18'h3dead, ldac_i=1: frame 24'h1F7AB4; ldacn low 2 cycles;
//    vout==18'h3dead; ready_o back 107 cycles after accept.
//  3 Write 18'h1cafe, ldac_i=0: ldacn stays 1 and vout stays 18'h3dead.
//    Then write 18'h1cafe, ldac_i=1: vout==18'h1cafe.
//  4 Read addr 001: frames 24'h900000 then 24'h000000; rdata_valid_o pulses once;
//    rdata_o[19:2]==18'h1cafe.
//  5 valid_i held high 300 cycles with fixed write: exactly 3 frames.
//    syncn high >=4 cycles between frames; no sclk edge while syncn=1.
//  6 rst_n low during bit 10 of a frame: next edge syncn=1, sclk=0, ldacn=1, ready_o=0,
//    dac_resetn_o=0. After release, init sequence repeats (24'h200002 resent).

Source files
------------

// File: rtl/ad5781_interface_pkg.sv
// ---------------------------------------------------------------------------
// ad5781_interface_pkg
//   Shared definitions for the AD5781 SPI interface: register addresses,
//   frame layout, FSM state encodings and frame-building helpers.
//   Imported by ad5781_interface and ad5781_interface_spi_shifter.
// ---------------------------------------------------------------------------
package ad5781_interface_pkg;

  localparam int FRAME_W = 24;   // bits per SPI frame
  localparam int RW_BIT  = 23;   // 1 = read, 0 = write
  localparam int BIT_W   = 5;    // bit index 23..0

  localparam logic [2:0] ADDR_NOP    = 3'b000;
  localparam logic [2:0] ADDR_DAC    = 3'b001;
  localparam logic [2:0] ADDR_CTRL   = 3'b010;
  localparam logic [2:0] ADDR_CLR    = 3'b011;
  localparam logic [2:0] ADDR_SWCTRL = 3'b100;

  // The second frame of a readback clocks out zeros while sdo is captured.
  localparam logic [FRAME_W-1:0] NOP_FRAME = '0;

  // Top-level sequencing states.
  typedef enum logic [2:0] {
    ST_INIT_RST,
    ST_INIT_CLR,
    ST_FRAME,
    ST_GAP,
    ST_LDAC,
    ST_IDLE
  } ctrl_state_t;

  // Sub-phases of a single frame, owned by the shifter.
  typedef enum logic [2:0] {
    SH_IDLE,
    SH_SETUP,
    SH_HIGH,
    SH_LOW,
    SH_HOLD
  } shift_state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Control-register write frame for a 20-bit payload.
  function automatic logic [FRAME_W-1:0] ctrl_frame(input logic [19:0] payload);
    return {1'b0, ADDR_CTRL, payload};
  endfunction

  // Build the 24-bit frame for a host command. The DAC register holds its
  // 18-bit code in bits [19:2]; the control-style registers take the payload
  // right-aligned.
  function automatic logic [FRAME_W-1:0] frame_word(input logic        rd,
                                                    input logic [2:0]  addr,
                                                    input logic [17:0] data);
    if (rd) begin
      return {1'b1, addr, 20'h0};
    end
    case (addr)
      ADDR_CTRL, ADDR_CLR, ADDR_SWCTRL: return {1'b0, addr, 2'b00, data};
      default:                          return {1'b0, addr, data, 2'b00};
    endcase
  endfunction

endpackage

// File: rtl/ad5781_interface_spi_shifter.sv
// ---------------------------------------------------------------------------
// ad5781_interface_spi_shifter
//   Serialises one 24-bit word MSB first on syncn/sclk/sdin and captures the
//   24 bits returned on sdo. sdin changes with each sclk rise; sdo is sampled
//   on the clk edge that drops sclk.
//
//   Frame shape: syncn falls, SYNC_SETUP cycles, 24 x (SCLK_DIV high +
//   SCLK_DIV low), SYNC_SETUP cycles, syncn rises.
//
// Ports
//   clk, rst_n  clock, synchronous active-low reset
//   start       begin a frame (honoured only while idle)
//   tx_word     word to send, captured on the start edge
//   sdo         serial data from the DAC
//   busy        frame in progress
//   done        high in the last cycle before syncn rises; rx_word valid
//   rx_word     bits captured from sdo, MSB first
//   syncn, sclk, sdin  DAC serial pins
// ---------------------------------------------------------------------------
module ad5781_interface_spi_shifter
  import ad5781_interface_pkg::*;
#(
  parameter int SCLK_DIV   = 2,
  parameter int SYNC_SETUP = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [FRAME_W-1:0] tx_word,
  input  logic               sdo,
  output logic               busy,
  output logic               done,
  output logic [FRAME_W-1:0] rx_word,
  output logic               syncn,
  output logic               sclk,
  output logic               sdin
);

  localparam int CNT_W = $clog2(max_of(SCLK_DIV, SYNC_SETUP) + 1);

  shift_state_t       state;
  logic [CNT_W-1:0]   cnt;
  logic [BIT_W-1:0]   bit_idx;
  logic [FRAME_W-1:0] tx_sr;
  logic [FRAME_W-1:0] rx_sr;
  logic               cnt_last;

  assign cnt_last = (cnt == CNT_W'(1));
  assign busy     = (state != SH_IDLE);
  assign done     = (state == SH_HOLD) && cnt_last;
  assign rx_word  = rx_sr;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and the order of statements does not matter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= SH_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      syncn   <= 1'b1;
      sclk    <= 1'b0;
      sdin    <= 1'b0;
    end else begin
      case (state)
        SH_IDLE: begin
          if (start) begin
            syncn <= 1'b0;
            tx_sr <= tx_word;
            cnt   <= CNT_W'(SYNC_SETUP);
            state <= SH_SETUP;
          end
        end
        SH_SETUP: begin
          if (cnt_last) begin
            // First rising edge carries the MSB.
            sclk    <= 1'b1;
            sdin    <= tx_sr[FRAME_W-1];
            tx_sr   <= {tx_sr[FRAME_W-2:0], 1'b0};
            bit_idx <= BIT_W'(FRAME_W - 1);
            cnt     <= CNT_W'(SCLK_DIV);
            state   <= SH_HIGH;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SH_HIGH: begin
          if (cnt_last) begin
            sclk  <= 1'b0;
            rx_sr <= {rx_sr[FRAME_W-2:0], sdo};
            cnt   <= CNT_W'(SCLK_DIV);
            state <= SH_LOW;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SH_LOW: begin
          if (cnt_last) begin
            if (bit_idx == '0) begin
              cnt   <= CNT_W'(SYNC_SETUP);
              state <= SH_HOLD;
            end else begin
              sclk    <= 1'b1;
              sdin    <= tx_sr[FRAME_W-1];
              tx_sr   <= {tx_sr[FRAME_W-2:0], 1'b0};
              bit_idx <= bit_idx - 1'b1;
              cnt     <= CNT_W'(SCLK_DIV);
              state   <= SH_HIGH;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SH_HOLD: begin
          if (cnt_last) begin
            syncn <= 1'b1;
            sdin  <= 1'b0;
            state <= SH_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= SH_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ad5781_interface.sv
// ---------------------------------------------------------------------------
// ad5781_interface
//   SPI master for the AD5781 18-bit DAC. After reset it pulses the DAC
//   RESET pin, releases CLR and writes the control register. It then accepts
//   register commands on a valid/ready handshake, sends each as a 24-bit
//   frame, optionally pulses LDAC after a DAC-register write, and performs
//   readback as a read frame followed by an automatic NOP frame.
//
// Ports
//   clk, rst_n     clock, synchronous active-low reset
//   data_i         DAC code / register payload
//   addr_i         register address
//   read_i         1 = readback command
//   ldac_i         1 = pulse ldacn after a write to the DAC register
//   valid_i        command valid
//   ready_o        idle, command can be accepted
//   rdata_o        last readback frame
//   rdata_valid_o  one-cycle pulse when rdata_o updates
//   dac_*          DAC pins (resetn, clrn, syncn, sclk, sdin, ldacn, sdo)
// ---------------------------------------------------------------------------
module ad5781_interface
  import ad5781_interface_pkg::*;
#(
  parameter int          SCLK_DIV     = 2,
  parameter int          SYNC_SETUP   = 2,
  parameter int          SYNC_HIGH    = 4,
  parameter int          LDAC_WIDTH   = 2,
  parameter int          RESET_CYCLES = 16,
  parameter logic [19:0] INIT_CTRL    = 20'h2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [17:0]        data_i,
  input  logic [2:0]         addr_i,
  input  logic               read_i,
  input  logic               ldac_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [FRAME_W-1:0] rdata_o,
  output logic               rdata_valid_o,
  output logic               dac_resetn_o,
  output logic               dac_clrn_o,
  output logic               dac_syncn_o,
  output logic               dac_sclk_o,
  output logic               dac_sdin_o,
  output logic               dac_ldacn_o,
  input  logic               dac_sdo_i
);

  localparam int CNT_MAX = max_of(max_of(max_of(SCLK_DIV, SYNC_SETUP),
                                         max_of(SYNC_HIGH, LDAC_WIDTH)),
                                  RESET_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ctrl_state_t        state;
  logic [CNT_W-1:0]   cnt;
  logic [FRAME_W-1:0] tx_word;
  logic               cmd_read;
  logic               ldac_pend;
  logic               need_second;   // read frame sent, NOP frame still due
  logic               second_frame;  // NOP frame of a readback in flight
  logic               cnt_last;
  logic               gap_last;
  logic               sh_start;
  logic               sh_busy;
  logic               sh_done;
  logic [FRAME_W-1:0] sh_rx;

  assign cnt_last = (cnt == CNT_W'(1));
  assign gap_last = (state == ST_GAP) && cnt_last;

  // A fresh frame starts on the first FRAME cycle. The readback NOP frame
  // is launched straight from the last gap cycle so syncn falls exactly
  // SYNC_HIGH cycles after it rose.
  assign sh_start = ((state == ST_FRAME) && !sh_busy) || (gap_last && need_second);

  ad5781_interface_spi_shifter #(
    .SCLK_DIV   (SCLK_DIV),
    .SYNC_SETUP (SYNC_SETUP)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (sh_start),
    .tx_word (tx_word),
    .sdo     (dac_sdo_i),
    .busy    (sh_busy),
    .done    (sh_done),
    .rx_word (sh_rx),
    .syncn   (dac_syncn_o),
    .sclk    (dac_sclk_o),
    .sdin    (dac_sdin_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_INIT_RST;
      cnt           <= CNT_W'(RESET_CYCLES);
      tx_word       <= ctrl_frame(INIT_CTRL);
      cmd_read      <= 1'b0;
      ldac_pend     <= 1'b0;
      need_second   <= 1'b0;
      second_frame  <= 1'b0;
      ready_o       <= 1'b0;
      rdata_o       <= '0;
      rdata_valid_o <= 1'b0;
      dac_resetn_o  <= 1'b0;
      dac_clrn_o    <= 1'b0;
      dac_ldacn_o   <= 1'b1;
    end else begin
      rdata_valid_o <= 1'b0;
      case (state)
        ST_INIT_RST: begin
          if (cnt_last) begin
            dac_resetn_o <= 1'b1;
            cnt          <= CNT_W'(SYNC_HIGH);
            state        <= ST_INIT_CLR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_INIT_CLR: begin
          // tx_word already holds the control frame from reset.
          if (cnt_last) begin
            dac_clrn_o <= 1'b1;
            state      <= ST_FRAME;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_FRAME: begin
          if (sh_done) begin
            cnt   <= CNT_W'(SYNC_HIGH);
            state <= ST_GAP;
            if (second_frame) begin
              rdata_o       <= sh_rx;
              rdata_valid_o <= 1'b1;
              second_frame  <= 1'b0;
            end else if (cmd_read) begin
              need_second <= 1'b1;
              tx_word     <= NOP_FRAME;
            end
          end
        end
        ST_GAP: begin
          if (cnt_last) begin
            if (need_second) begin
              need_second  <= 1'b0;
              second_frame <= 1'b1;
              state        <= ST_FRAME;
            end else if (ldac_pend) begin
              dac_ldacn_o <= 1'b0;
              cnt         <= CNT_W'(LDAC_WIDTH);
              state       <= ST_LDAC;
            end else begin
              ready_o <= 1'b1;
              state   <= ST_IDLE;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_LDAC: begin
          if (cnt_last) begin
            dac_ldacn_o <= 1'b1;
            ready_o     <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_IDLE: begin
          if (valid_i && ready_o) begin
            tx_word   <= frame_word(read_i, addr_i, data_i);
            cmd_read  <= read_i;
            ldac_pend <= ldac_i && !read_i && (addr_i == ADDR_DAC);
            ready_o   <= 1'b0;
            state     <= ST_FRAME;
          end
        end
        default: state <= ST_INIT_RST;
      endcase
    end
  end

endmodule
